// File: rtl/sig_gen_if.sv
// sig_gen_if
// Bundles the control and sample signals of the test-waveform source.
//   master : the side that issues start/stop and configuration and that
//            consumes the generated samples (testbench or controller).
//   slave  : the waveform generator itself.
// Signals:
//   i_start  one-cycle pulse, latch configuration and (re)start
//   i_stop   one-cycle pulse, halt and return to idle
//   i_mode   waveform select (3 bits)
//   i_div    sample period minus 1 (DIV_W bits)
//   i_level  constant value for LEVEL mode (3 bits)
//   o_sample current 3-bit sample
//   o_strobe one-cycle pulse whenever o_sample updates
//   o_sync   strobe companion marking the first sample of a period
//   o_busy   high while generating
interface sig_gen_if #(parameter int DIV_W = 8);
    logic             i_start;
    logic             i_stop;
    logic [2:0]       i_mode;
    logic [DIV_W-1:0] i_div;
    logic [2:0]       i_level;
    logic [2:0]       o_sample;
    logic             o_strobe;
    logic             o_sync;
    logic             o_busy;

    modport master (
        output i_start, i_stop, i_mode, i_div, i_level,
        input  o_sample, o_strobe, o_sync, o_busy
    );

    modport slave (
        input  i_start, i_stop, i_mode, i_div, i_level,
        output o_sample, o_strobe, o_sync, o_busy
    );
endinterface

// File: rtl/sig_gen.sv
// sig_gen
// Programmable 3-bit test-waveform source feeding the FIR filter's signal
// input. Produces zero, impulse, step, ramp, triangle, square, LFSR noise
// or a constant level, one sample per divider tick.
// Ports:
//   i_clk  system clock (shared with the FIR filter)
//   i_rst  asynchronous active-high reset
//   bus    sig_gen_if.slave: start/stop/config in, sample/strobe/sync/busy out
// Build option:
//   SIG_GEN_LFSR_EN  when defined the noise LFSR is built; otherwise mode 6
//                    degenerates to the ZERO waveform.
module sig_gen #(
    parameter int DIV_W = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    sig_gen_if.slave   bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       level_q, level_d;
    logic [DIV_W-1:0] dcnt_q, dcnt_d;
    logic [3:0]       p_q, p_d;
    logic [2:0]       sample_q, sample_d;
    logic             strobe_q, strobe_d;
    logic             sync_q, sync_d;
    logic             busy_q, busy_d;

    // Working values for the current tick: on a start edge these come from
    // the bus, otherwise from the latched configuration.
    logic             tick;
    logic             first;
    logic [2:0]       cur_mode;
    logic [2:0]       cur_level;
    logic [3:0]       cur_phase;
    logic [2:0]       noise;

`ifdef SIG_GEN_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] lfsr_base;
`endif

    // Last phase index before wrap; non-periodic modes keep p at 0.
    function automatic logic [3:0] last_phase(input logic [2:0] mode);
        case (mode)
            3'd3, 3'd5: last_phase = 4'd7;
            3'd4:       last_phase = 4'd13;
            default:    last_phase = 4'd0;
        endcase
    endfunction

    function automatic logic periodic(input logic [2:0] mode);
        periodic = (mode == 3'd3) || (mode == 3'd4) || (mode == 3'd5);
    endfunction

    function automatic logic [2:0] wave(input logic [2:0] mode,
                                        input logic [3:0] phase,
                                        input logic       is_first,
                                        input logic [2:0] level,
                                        input logic [2:0] rnd);
        case (mode)
            3'd1:    wave = is_first ? 3'd7 : 3'd0;
            3'd2:    wave = 3'd7;
            3'd3:    wave = phase[2:0];
            // Descending half of the triangle mirrors around phase 7.
            3'd4:    wave = (phase <= 4'd7) ? phase[2:0] : 3'(4'd14 - phase);
            3'd5:    wave = phase[2] ? 3'd0 : 3'd7;
            3'd6:    wave = rnd;
            3'd7:    wave = level;
            default: wave = 3'd0;
        endcase
    endfunction

    // Next-state and output computation. A start edge is itself a tick,
    // so the first sample is registered on the same edge that sees i_start.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        div_d     = div_q;
        level_d   = level_q;
        dcnt_d    = dcnt_q;
        p_d       = p_q;
        sample_d  = sample_q;
        strobe_d  = 1'b0;
        sync_d    = 1'b0;
        busy_d    = busy_q;
        tick      = 1'b0;
        first     = 1'b0;
        cur_mode  = mode_q;
        cur_level = level_q;
        cur_phase = p_q;

        if (bus.i_stop) begin
            state_d  = IDLE;
            dcnt_d   = '0;
            p_d      = 4'd0;
            sample_d = 3'd0;
            busy_d   = 1'b0;
        end else if (bus.i_start) begin
            state_d   = RUN;
            mode_d    = bus.i_mode;
            div_d     = bus.i_div;
            level_d   = bus.i_level;
            dcnt_d    = '0;
            tick      = 1'b1;
            first     = 1'b1;
            cur_mode  = bus.i_mode;
            cur_level = bus.i_level;
            cur_phase = 4'd0;
        end else if (state_q == RUN) begin
            if (dcnt_q == div_q) begin
                tick   = 1'b1;
                dcnt_d = '0;
            end else begin
                dcnt_d = DIV_W'(dcnt_q + 1'b1);
            end
        end

`ifdef SIG_GEN_LFSR_EN
        lfsr_d    = lfsr_q;
        lfsr_base = first ? 8'h01 : lfsr_q;
        noise     = 3'd0;
        if (tick) begin
            lfsr_d = {lfsr_base[6:0],
                      lfsr_base[7] ^ lfsr_base[5] ^ lfsr_base[4] ^ lfsr_base[3]};
            noise  = lfsr_d[2:0];
        end
`else
        noise = 3'd0;
`endif

        if (tick) begin
            sample_d = wave(cur_mode, cur_phase, first, cur_level, noise);
            strobe_d = 1'b1;
            sync_d   = first || (periodic(cur_mode) && cur_phase == 4'd0);
            p_d      = (cur_phase == last_phase(cur_mode)) ? 4'd0 : cur_phase + 4'd1;
            busy_d   = 1'b1;
        end
    end

    // All state and outputs are registered; reset forces the idle picture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            mode_q   <= 3'd0;
            div_q    <= '0;
            level_q  <= 3'd0;
            dcnt_q   <= '0;
            p_q      <= 4'd0;
            sample_q <= 3'd0;
            strobe_q <= 1'b0;
            sync_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            div_q    <= div_d;
            level_q  <= level_d;
            dcnt_q   <= dcnt_d;
            p_q      <= p_d;
            sample_q <= sample_d;
            strobe_q <= strobe_d;
            sync_q   <= sync_d;
            busy_q   <= busy_d;
        end
    end

`ifdef SIG_GEN_LFSR_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    assign bus.o_sample = sample_q;
    assign bus.o_strobe = strobe_q;
    assign bus.o_sync   = sync_q;
    assign bus.o_busy   = busy_q;

endmodule

// File: doc/sig_gen.md
# sig_gen

Programmable 3-bit test-waveform source that drives the `signal` input of the 8-tap FIR filter. It emits zero, impulse, step, ramp, triangle, square, pseudo-random noise or a constant level. Each new sample is paced by a programmable clock divider. Impulse mode exists so the bench can read the filter's coefficient sequence directly off `result`.

## Interface
Parameters:
- `DIV_W`, default 8: width of the sample-period divider.

Ports (one clock; reset is asynchronous and active-high):
- `i_clk`  input  1  system clock, the same clock as the FIR filter.
- `i_rst`  input  1  asynchronous active-high reset.
- `i_start`  input  1  one-cycle pulse: latch configuration and (re)start generation.
- `i_stop`  input  1  one-cycle pulse: halt and return to idle.
- `i_mode`  input  3  waveform select, latched on start.
- `i_div`  input  DIV_W  sample period minus 1, latched on start.
- `i_level`  input  3  constant value for mode 7, latched on start.
- `o_sample`  output  3  current sample; connects to the FIR `signal` input.
- `o_strobe`  output  1  high for one cycle each time `o_sample` updates.
- `o_sync`  output  1  high with the strobe on the first sample of each waveform period.
- `o_busy`  output  1  high while in the RUN state.

## Operation
- State machine with two states:
  - IDLE → RUN when `i_start` is sampled high.
  - RUN → IDLE when `i_stop` is sampled high.
  - RUN → RUN when `i_start` is sampled high again: re-latch the configuration, clear the phase and the divider, and reseed the LFSR.
  - `i_start` and `i_stop` sampled high together: stop wins.
- Configuration inputs are ignored outside a start edge.
- Divider counter `dcnt` (DIV_W bits) generates the sample tick:
  - A tick occurs at the start edge itself, then whenever `dcnt == div`.
  - `dcnt` clears on every tick and otherwise increments.
  - `div = 0` gives a tick every cycle; `div = 2^DIV_W - 1` gives a tick every 2^DIV_W cycles.
- Phase counter `p` advances once per tick and wraps at the mode's period.
- Waveforms, listed as `mode`: sample sequence per tick:
  - 0 ZERO: 0.
  - 1 IMPULSE: 7 on the first tick, 0 afterwards.
  - 2 STEP: 7.
  - 3 RAMP: 0,1,…,7, then repeats; period 8.
  - 4 TRIANGLE: 0,1,…,7,6,…,1, then repeats; period 14.
  - 5 SQUARE: 7,7,7,7,0,0,0,0; period 8.
  - 6 NOISE: 8-bit Fibonacci LFSR `l`.
    - Seeded to 0x01 on start.
    - Each tick: `fb = l[7]^l[5]^l[4]^l[3]`, then `l <= {l[6:0],fb}`.
    - Sample = new `l[2:0]`.
  - 7 LEVEL: latched `i_level`.
- `o_sync` rules:
  - Modes 3–5: asserted on every tick where `p = 0`.
  - Modes 0, 1, 2, 6, 7: asserted on the first tick after start only.
- On entering IDLE, `o_sample` is driven to 0 and `o_strobe`, `o_sync` and `o_busy` are deasserted.
- Arithmetic:
  - All waveform values are unsigned 3-bit; none saturates or overflows its range.
  - The TRIANGLE phase counter is 4 bits, running 0..13.

## Timing
- All outputs are registered.
- Reset values: `o_sample = 0`, `o_strobe = 0`, `o_sync = 0`, `o_busy = 0`; state IDLE; `dcnt = 0`; `p = 0`; LFSR = 0x01.
- Start to first sample: 1 cycle. The edge that samples `i_start` loads the first sample, so `o_strobe = 1` and `o_busy = 1` in the following cycle.
- Subsequent samples follow every `div+1` cycles.
- `o_sample` holds its value between strobes.
- Stop latency: 1 cycle. In the cycle after `i_stop` is sampled, outputs hold their IDLE values.
- A start in RUN restarts cleanly: the first sample of the new configuration appears 1 cycle later, with no stale strobe.
- Reset mid-run: outputs go to their reset values immediately (asynchronously). Generation resumes only on a new `i_start`.

## Configuration
- `SIG_GEN_LFSR_EN`:
  - Defined: the LFSR is built and mode 6 produces noise as specified.
  - Undefined: no LFSR logic is built, and mode 6 behaves exactly as mode 0 (ZERO), including its `o_sync` behaviour.

## Test plan
- Reset check: assert `i_rst` mid-RUN → all outputs are 0 asynchronously, and stay 0 after release until `i_start`.
- Impulse into FIR: mode 1, div 0, start → `o_sample` is 7,0,0,0,… with `o_strobe` high every cycle and `o_sync` high on the first sample only. The FIR `result` then follows the 7×coefficient sequence 0,7,14,…,49 on successive cycles.
- Ramp with divider: mode 3, div 2 → strobes every 3 cycles and samples 0,1,…,7,0. `o_sync` is high on samples 0 and 8; `o_sample` holds between strobes.
- Triangle wrap: mode 4, div 0 → samples 0..7, 6..1, 0. `o_sync` is high at tick 0 and at tick 14.
- Noise (`SIG_GEN_LFSR_EN` defined): mode 6, div 0 → first samples are 2,4,0,1. Restart → the sequence repeats 2,4,0,1. With the macro undefined → all samples are 0.
- Control collisions:
  - `i_start` and `i_stop` in the same cycle during RUN → IDLE, `o_busy = 0`.
  - Start in RUN with a new mode 7, level 5 → the next cycle shows `o_sample = 5` with `o_strobe = 1` and `o_sync = 1`.
